// File: rtl/jtag_host_driver_if.sv
// rtl/jtag_host_driver_if.sv - host command/response bundle for jtag_host_driver
//
// Purpose: groups the host-side command handshake and response strobe.
// Signals:
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_op               00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
//   cmd_len              shift bit count or IDLE tck count
//   cmd_data             tdi bits, LSB shifted first
//   clk_div              tck half-period = clk_div+1 sys_clk cycles
//   rsp_valid/rsp_data   one-cycle completion strobe with captured tdo bits
//   busy                 inverse of cmd_ready
// Modports: master = host side, slave = driver side.
interface jtag_host_driver_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W) + 1,
  parameter int DIV_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic [DIV_W-1:0]  clk_div;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, clk_div,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, clk_div,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_host_driver.sv
// rtl/jtag_host_driver.sv - sys_clk-domain JTAG master executing one host command at a time
//
// Purpose: drives tck/tms/tdi/trst into a TAP and captures tdo for RESET, SHIFT_IR,
// SHIFT_DR and IDLE commands; returns captured bits on a one-cycle response strobe.
// Ports:
//   sys_clk   single clock, all logic on posedge
//   reset     synchronous, active-high
//   host      jtag_host_driver_if.slave (command handshake, response, busy)
//   tck/tms/tdi  registered JTAG drive
//   trst      registered TAP reset, active-low
//   tdo       serial data from the TAP
module jtag_host_driver #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W) + 1,
  parameter int DIV_W  = 8
) (
  input  logic                sys_clk,
  input  logic                reset,
  jtag_host_driver_if.slave   host,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  output logic                trst,
  input  logic                tdo
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRST  = 3'd1;
  localparam logic [2:0] ST_PRE   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_POST  = 3'd4;
  localparam logic [2:0] ST_RSP   = 3'd5;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  // Number of tck edges spent in each phase for a given op.
  function automatic logic [LEN_W-1:0] pre_count(input logic [1:0] op);
    logic [LEN_W-1:0] n;
    case (op)
      OP_RESET: n = LEN_W'(6);
      OP_IR:    n = LEN_W'(4);
      OP_DR:    n = LEN_W'(3);
      default:  n = '0;
    endcase
    return n;
  endfunction

  function automatic logic [LEN_W-1:0] shift_count(input logic [1:0] op,
                                                   input logic [LEN_W-1:0] len);
    return (op == OP_RESET) ? '0 : len;
  endfunction

  function automatic logic [LEN_W-1:0] post_count(input logic [1:0] op);
    return (op == OP_IR || op == OP_DR) ? LEN_W'(2) : '0;
  endfunction

  // Resolve a candidate (state, edge index) to the next edge that actually
  // exists, skipping empty phases; ST_RSP means the command has no edges left.
  function automatic logic [LEN_W+2:0] locate(input logic [1:0]       op,
                                              input logic [LEN_W-1:0] len,
                                              input logic [2:0]       st_in,
                                              input logic [LEN_W-1:0] idx_in);
    logic [2:0]       st;
    logic [LEN_W-1:0] ix;
    st = st_in;
    ix = idx_in;
    if (st == ST_PRE && ix >= pre_count(op)) begin
      st = ST_SHIFT;
      ix = '0;
    end
    if (st == ST_SHIFT && ix >= shift_count(op, len)) begin
      st = ST_POST;
      ix = '0;
    end
    if (st == ST_POST && ix >= post_count(op)) begin
      st = ST_RSP;
      ix = '0;
    end
    return {st, ix};
  endfunction

  // tms for a given edge. With len=0 the last PRE edge leaves Capture for
  // Exit1 directly, so the Shift state is never entered.
  function automatic logic tms_of(input logic [1:0]       op,
                                  input logic [LEN_W-1:0] len,
                                  input logic [2:0]       st,
                                  input logic [LEN_W-1:0] ix);
    logic t;
    t = 1'b0;
    case (st)
      ST_PRE: begin
        case (op)
          OP_RESET: t = (ix != LEN_W'(5));
          OP_IR:    t = (ix < LEN_W'(2)) || (ix == LEN_W'(3) && len == '0);
          OP_DR:    t = (ix == '0) || (ix == LEN_W'(2) && len == '0);
          default:  t = 1'b0;
        endcase
      end
      ST_SHIFT: t = (op != OP_IDLE) && (ix == len - LEN_W'(1));
      ST_POST:  t = (ix == '0);
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic tdi_of(input logic [1:0]        op,
                                  input logic [DATA_W-1:0] data,
                                  input logic [2:0]        st,
                                  input logic [LEN_W-1:0]  ix);
    logic [DATA_W-1:0] sh;
    sh = data >> ix;
    return (st == ST_SHIFT && op != OP_IDLE) ? sh[0] : 1'b0;
  endfunction

  logic [2:0]        state;
  logic [LEN_W-1:0]  idx;
  logic              phase_hi;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        op_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] cap_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [LEN_W-1:0]  len_c;
  logic [LEN_W+2:0]  loc_start;
  logic [LEN_W+2:0]  loc_next;
  logic [2:0]        start_st;
  logic [LEN_W-1:0]  start_idx;
  logic [2:0]        next_st;
  logic [LEN_W-1:0]  next_idx;
  logic              accept;

  always_comb begin
    len_c     = (host.cmd_len > LEN_MAX) ? LEN_MAX : host.cmd_len;
    loc_start = locate(host.cmd_op, len_c, ST_PRE, '0);
    if (state == ST_TRST) begin
      loc_next = locate(op_q, len_q, ST_PRE, '0);
    end else begin
      loc_next = locate(op_q, len_q, state, idx + 1'b1);
    end
  end

  assign start_st  = loc_start[LEN_W+2:LEN_W];
  assign start_idx = loc_start[LEN_W-1:0];
  assign next_st   = loc_next[LEN_W+2:LEN_W];
  assign next_idx  = loc_next[LEN_W-1:0];
  assign accept    = host.cmd_valid && cmd_ready_q;

  assign host.cmd_ready = cmd_ready_q;
  assign host.busy      = ~cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      phase_hi    <= 1'b0;
      div_cnt     <= '0;
      op_q        <= OP_IDLE;
      len_q       <= '0;
      data_q      <= '0;
      div_q       <= '0;
      cap_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tck         <= 1'b0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      trst        <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE, ST_RSP: begin
          state <= ST_IDLE;
          if (accept) begin
            op_q     <= host.cmd_op;
            len_q    <= len_c;
            data_q   <= host.cmd_data;
            div_q    <= host.clk_div;
            cap_q    <= '0;
            div_cnt  <= '0;
            phase_hi <= 1'b0;
            tck      <= 1'b0;
            if (host.cmd_op == OP_RESET) begin
              state       <= ST_TRST;
              idx         <= '0;
              trst        <= 1'b0;
              tms         <= 1'b1;
              tdi         <= 1'b0;
              cmd_ready_q <= 1'b0;
            end else if (start_st == ST_RSP) begin
              // IDLE with zero count completes immediately; ready never drops.
              state       <= ST_RSP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state       <= start_st;
              idx         <= start_idx;
              tms         <= tms_of(host.cmd_op, len_c, start_st, start_idx);
              tdi         <= tdi_of(host.cmd_op, host.cmd_data, start_st, start_idx);
              cmd_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          if (div_cnt != div_q) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!phase_hi) begin
              // End of low phase: raise tck (held low during TRST) and sample tdo.
              phase_hi <= 1'b1;
              if (state != ST_TRST) tck <= 1'b1;
              if (state == ST_SHIFT && op_q != OP_IDLE) begin
                cap_q <= cap_q | (DATA_W'(tdo) << idx);
              end
            end else begin
              // End of high phase: drop tck and present the next edge's tms/tdi.
              phase_hi <= 1'b0;
              tck      <= 1'b0;
              trst     <= 1'b1;
              if (next_st == ST_RSP) begin
                state       <= ST_RSP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= cap_q;
                cmd_ready_q <= 1'b1;
                tdi         <= 1'b0;
              end else begin
                state <= next_st;
                idx   <= next_idx;
                tms   <= tms_of(op_q, len_q, next_st, next_idx);
                tdi   <= tdi_of(op_q, data_q, next_st, next_idx);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host_driver.sv
// tb/tb_jtag_host_driver.sv - directed testbench for jtag_host_driver with a behavioural TAP
module tb_jtag_host_driver;

  localparam logic [31:0] IDCODE = 32'h4BA0_0477;

  localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5,
                 PAU_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10,
                 SH_IR = 11, EX1_IR = 12, PAU_IR = 13, EX2_IR = 14, UPD_IR = 15;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic tck, tms, tdi, trst;
  logic tdo = 1'b0;

  jtag_host_driver_if #(.DATA_W(32)) host_if ();

  jtag_host_driver #(.DATA_W(32)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .host    (host_if),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
    .trst    (trst),
    .tdo     (tdo)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural TAP: 4-bit IR, IDCODE opcode 0001, everything else is bypass.
  int          tap_st = TLR;
  logic [3:0]  ir     = 4'b0001;
  logic [3:0]  ir_sr  = 4'b0000;
  logic [31:0] dr_sr  = 32'h0;
  int          upd_dr_cnt = 0;

  function automatic int next_tap(input int s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst) begin
    if (trst === 1'b0) begin
      tap_st <= TLR;
      ir     <= 4'b0001;
    end else begin
      case (tap_st)
        CAP_DR: dr_sr <= (ir == 4'b0001) ? IDCODE : 32'h0;
        SH_DR:  dr_sr <= (ir == 4'b0001) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
        CAP_IR: ir_sr <= 4'b0001;
        SH_IR:  ir_sr <= {tdi, ir_sr[3:1]};
        UPD_IR: ir    <= ir_sr;
        UPD_DR: upd_dr_cnt <= upd_dr_cnt + 1;
        default: ;
      endcase
      tap_st <= next_tap(tap_st, tms);
    end
  end

  always @(negedge tck) begin
    tdo <= (tap_st == SH_DR) ? dr_sr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;
  end

  // Edge history and cycle counters (sampled values of the preceding cycle).
  int   rises = 0;
  logic tms_hist [0:511];
  logic tdi_hist [0:511];
  int   rsp_cnt = 0, acc_cnt = 0, trst_lo = 0, hi_cyc = 0, lo_busy = 0;

  always @(posedge tck) begin
    tms_hist[rises % 512] <= tms;
    tdi_hist[rises % 512] <= tdi;
    rises <= rises + 1;
  end

  always @(posedge sys_clk) begin
    if (host_if.rsp_valid === 1'b1) rsp_cnt++;
    if (!reset && host_if.cmd_valid && host_if.cmd_ready) acc_cnt++;
    if (trst === 1'b0) trst_lo++;
    if (tck === 1'b1) hi_cyc++;
    if (tck === 1'b0 && host_if.busy === 1'b1) lo_busy++;
  end

  int n_vec  = 0;
  int n_miss = 0;
  bit rdy_at_rsp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tms_seq(input int s, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tms_hist[(s + i) % 512];
    return v;
  endfunction

  function automatic logic [63:0] tdi_seq(input int s, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tdi_hist[(s + i) % 512];
    return v;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input logic [7:0] div, input bit hold,
                         output logic [31:0] rdata, output int start_rise);
    bit seen;
    start_rise = rises;
    @(negedge sys_clk);
    host_if.cmd_op    = op;
    host_if.cmd_len   = len;
    host_if.cmd_data  = data;
    host_if.clk_div   = div;
    host_if.cmd_valid = 1'b1;
    @(negedge sys_clk);
    if (!hold) host_if.cmd_valid = 1'b0;
    seen  = 1'b0;
    rdata = '0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      if (host_if.rsp_valid === 1'b1) begin
        seen       = 1'b1;
        rdata      = host_if.rsp_data;
        rdy_at_rsp = host_if.cmd_ready;
        host_if.cmd_valid = 1'b0;
      end else begin
        @(negedge sys_clk);
      end
    end
    if (!seen) chk("rsp_timeout", 64'd0, 64'd1);
    host_if.cmd_valid = 1'b0;
    @(negedge sys_clk);
  endtask

  logic [31:0] rd;
  int s, r0, a0, t0, h0, l0, u0;

  initial begin
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'b00;
    host_if.cmd_len   = '0;
    host_if.cmd_data  = '0;
    host_if.clk_div   = '0;

    repeat (3) @(negedge sys_clk);
    chk("rst_tck",       tck,               0);
    chk("rst_tms",       tms,               1);
    chk("rst_tdi",       tdi,               0);
    chk("rst_trst",      trst,              1);
    chk("rst_cmd_ready", host_if.cmd_ready, 1);
    chk("rst_busy",      host_if.busy,      0);
    chk("rst_rsp_valid", host_if.rsp_valid, 0);
    chk("rst_rsp_data",  host_if.rsp_data,  0);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    // 1. RESET with clk_div=0
    r0 = rsp_cnt; t0 = trst_lo;
    run_cmd(2'b00, 6'd0, 32'h0, 8'd0, 1'b0, rd, s);
    chk("t1_trst_cycles", trst_lo - t0,         2);
    chk("t1_rises",       rises - s,            6);
    chk("t1_tms",         tms_seq(s, 6),        64'h1F);
    chk("t1_rsp_cnt",     rsp_cnt - r0,         1);
    chk("t1_rsp_data",    rd,                   0);
    chk("t1_tap_rti",     tap_st,               RTI);

    // 2. SHIFT_IR len=4 loads IDCODE opcode
    run_cmd(2'b01, 6'd4, 32'h1, 8'd0, 1'b0, rd, s);
    chk("t2_rises",    rises - s,        10);
    chk("t2_tms",      tms_seq(s, 10),   64'h183);
    chk("t2_tdi",      tdi_seq(s + 4, 4), 64'h1);
    chk("t2_rsp_data", rd,               32'h1);
    chk("t2_ir",       ir,               4'b0001);
    chk("t2_tap_rti",  tap_st,           RTI);

    // 3. SHIFT_DR len=32 reads IDCODE
    run_cmd(2'b10, 6'd32, 32'h0, 8'd0, 1'b0, rd, s);
    chk("t3_rises",    rises - s,      37);
    chk("t3_tms",      tms_seq(s, 37), 64'h1 | (64'h1 << 34) | (64'h1 << 35));
    chk("t3_rsp_data", rd,             IDCODE);
    chk("t3_bit0",     rd[0],          1);
    chk("t3_tap_rti",  tap_st,         RTI);

    // 4. SHIFT_DR len=0
    u0 = upd_dr_cnt;
    run_cmd(2'b10, 6'd0, 32'hFFFF_FFFF, 8'd0, 1'b0, rd, s);
    chk("t4_rises",    rises - s,       5);
    chk("t4_tms",      tms_seq(s, 5),   64'h0D);
    chk("t4_rsp_data", rd,              0);
    chk("t4_upd_dr",   upd_dr_cnt - u0, 1);
    chk("t4_tap_rti",  tap_st,          RTI);

    // 5. IDLE len=2 at clk_div=3, cmd_valid held through busy
    a0 = acc_cnt; h0 = hi_cyc; l0 = lo_busy; r0 = rsp_cnt;
    run_cmd(2'b11, 6'd2, 32'hFFFF_FFFF, 8'd3, 1'b1, rd, s);
    chk("t5_rises",      rises - s,     2);
    chk("t5_tms",        tms_seq(s, 2), 0);
    chk("t5_tdi",        tdi_seq(s, 2), 0);
    chk("t5_hi_cycles",  hi_cyc - h0,   8);
    chk("t5_lo_cycles",  lo_busy - l0,  8);
    chk("t5_accepts",    acc_cnt - a0,  1);
    chk("t5_rsp_cnt",    rsp_cnt - r0,  1);
    chk("t5_ready_rsp",  rdy_at_rsp,    1);

    // IDLE len=0 responds the cycle after accept
    @(negedge sys_clk);
    host_if.cmd_op = 2'b11; host_if.cmd_len = 6'd0; host_if.cmd_valid = 1'b1;
    @(negedge sys_clk);
    host_if.cmd_valid = 1'b0;
    chk("idle0_rsp_valid", host_if.rsp_valid, 1);
    chk("idle0_ready",     host_if.cmd_ready, 1);
    @(negedge sys_clk);

    // 6. reset during SHIFT_DR, 11th shift bit
    s = rises; r0 = rsp_cnt;
    @(negedge sys_clk);
    host_if.cmd_op = 2'b10; host_if.cmd_len = 6'd32; host_if.cmd_data = 32'hA5A5_5A5A;
    host_if.clk_div = 8'd0; host_if.cmd_valid = 1'b1;
    @(negedge sys_clk);
    host_if.cmd_valid = 1'b0;
    for (int t = 0; t < 1000 && (rises - s) < 13; t++) @(negedge sys_clk);
    chk("t6_reach_bit10", rises - s, 13);
    chk("t6_busy_before", host_if.busy, 1);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("t6_tck",       tck,               0);
    chk("t6_tms",       tms,               1);
    chk("t6_trst",      trst,              1);
    chk("t6_cmd_ready", host_if.cmd_ready, 1);
    chk("t6_rsp_valid", host_if.rsp_valid, 0);
    reset = 1'b0;
    repeat (150) @(negedge sys_clk);
    chk("t6_no_rsp", rsp_cnt - r0, 0);

    // Recover the TAP, then an over-long shift is clamped to 32 bits
    run_cmd(2'b00, 6'd0, 32'h0, 8'd1, 1'b0, rd, s);
    chk("rec_tap_rti", tap_st, RTI);
    run_cmd(2'b10, 6'd40, 32'h0, 8'd0, 1'b0, rd, s);
    chk("clamp_rises",    rises - s, 37);
    chk("clamp_rsp_data", rd,        IDCODE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
